// File: rtl/sha512_pkg.sv
// Shared constants and state encoding for the SHA-512 message-level controller.
package sha512_pkg;

  localparam int BLK_W = 1024;
  localparam int DIG_W = 512;

  localparam logic [DIG_W-1:0] SHA512_H0 = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } msg_state_t;

endpackage

// File: rtl/sha512_msg_ctrl.sv
// Message sequencer for the sha512_block core: owns the chaining value, launches one
// compression per padded block and hands the final digest out over valid/ready.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | ready for a block; H/M held from the previous block
// ST_START | one-cycle core_start pulse, timeout counter loaded
// ST_WAIT  | core running; waiting for core_done or timeout
// ST_OUT   | digest presented, held until dig_ready; no block intake
module sha512_msg_ctrl
  import sha512_pkg::*;
#(
  parameter int CORE_TIMEOUT = 200,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic [BLK_W-1:0] blk_data,
  input  logic             blk_last,
  output logic             dig_valid,
  input  logic             dig_ready,
  output logic [DIG_W-1:0] digest,
  output logic             core_start,
  output logic [BLK_W-1:0] core_M,
  output logic [DIG_W-1:0] core_H,
  input  logic [DIG_W-1:0] core_H_out,
  input  logic             core_done,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] msg_blocks
);

  localparam int TMR_W = $clog2(CORE_TIMEOUT + 1);

  msg_state_t       state, state_nxt;
  logic [DIG_W-1:0] chain;
  logic             last_q;
  logic             in_msg;
  logic [TMR_W-1:0] tmr;
  logic             accept, done_ok, timeout;

  assign core_H  = chain;
  assign accept  = blk_valid & blk_ready;
  assign done_ok = (state == ST_WAIT) & core_done;
  // core_done on the expiry cycle takes priority over the abort
  assign timeout = (state == ST_WAIT) & ~core_done & (tmr == '0);

  always_comb begin
    state_nxt  = state;
    blk_ready  = 1'b0;
    core_start = 1'b0;
    dig_valid  = 1'b0;
    busy       = 1'b1;
    unique case (state)
      ST_IDLE: begin
        blk_ready = 1'b1;
        busy      = 1'b0;
        if (blk_valid) state_nxt = ST_START;
      end
      ST_START: begin
        core_start = 1'b1;
        state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done)       state_nxt = last_q ? ST_OUT : ST_IDLE;
        else if (tmr == '0)  state_nxt = ST_IDLE;
      end
      ST_OUT: begin
        dig_valid = 1'b1;
        if (dig_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      chain      <= SHA512_H0;
      core_M     <= '0;
      last_q     <= 1'b0;
      in_msg     <= 1'b0;
      tmr        <= '0;
      digest     <= '0;
      err        <= 1'b0;
      msg_blocks <= '0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        core_M <= blk_data;
        last_q <= blk_last;
        in_msg <= 1'b1;
        if (!in_msg) begin
          msg_blocks <= '0;
          err        <= 1'b0;
        end
      end

      // down-counter: WAIT lasts at most CORE_TIMEOUT cycles, expiring at zero
      if (state == ST_START)
        tmr <= TMR_W'(CORE_TIMEOUT - 1);
      else if (state == ST_WAIT && tmr != '0)
        tmr <= tmr - 1'b1;

      if (done_ok) begin
        chain <= core_H_out;
        if (msg_blocks != '1) msg_blocks <= msg_blocks + 1'b1;
        if (last_q) begin
          digest <= core_H_out;
          chain  <= SHA512_H0;
          in_msg <= 1'b0;
        end
      end

      if (timeout) begin
        err    <= 1'b1;
        chain  <= SHA512_H0;
        in_msg <= 1'b0;
      end
    end
  end

endmodule
